// File: rtl/dvi_fifo_scanout_pkg.sv
// Shared timing defaults, RGB444 expansion and underflow colour for the DVI scanout.
// SCANOUT_UNDERFLOW_MARK_EN selects a magenta underflow colour instead of black.
package dvi_scanout_pkg;

  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_H_ACTIVE   = 640;
  localparam int unsigned DEF_H_FP       = 16;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_BP       = 48;
  localparam int unsigned DEF_V_ACTIVE   = 480;
  localparam int unsigned DEF_V_FP       = 10;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BP       = 33;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

`ifdef SCANOUT_UNDERFLOW_MARK_EN
  localparam logic [11:0] UNDERFLOW_COLOR = 12'hF0F;
`else
  localparam logic [11:0] UNDERFLOW_COLOR = 12'h000;
`endif

  function automatic logic [11:0] expand_rgb444(input logic [2:0] rgb);
    return {{4{rgb[2]}}, {4{rgb[1]}}, {4{rgb[0]}}};
  endfunction

endpackage

// File: rtl/dvi_fifo_scanout_fifo.sv
// Synchronous pixel FIFO: registered pointers and occupancy count, head word exposed.
module pixel_fifo_sync
  import dvi_scanout_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dvi_fifo_scanout.sv
// 640x480@60 raster generator popping RGB111 pixels from a FIFO, RGB444 registered outputs.
// Build option: SCANOUT_UNDERFLOW_MARK_EN (magenta on underflowed active pixels).
module dvi_fifo_scanout
  import dvi_scanout_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  frame_buffer_color_in,
  input  logic        frame_buffer_fifo_write_enable,
  output logic        fifo_full,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [11:0] D,
  output logic        underflow
);

  localparam int unsigned HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCW = $clog2(HT);
  localparam int unsigned VCW = $clog2(VT);

  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [VCW-1:0] v_cnt_q, v_cnt_d;
  logic [31:0]    h_ext, v_ext;
  logic           active, fifo_empty, pop;
  logic [2:0]     head;

  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           blank_q, blank_d;
  logic [11:0]    d_q, d_d;
  logic           underflow_q, underflow_d;

  assign h_ext  = 32'(h_cnt_q);
  assign v_ext  = 32'(v_cnt_q);
  assign active = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
  assign pop    = active && !fifo_empty;

  pixel_fifo_sync #(
    .WIDTH (3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (frame_buffer_fifo_write_enable),
    .data_i  (frame_buffer_color_in),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    h_cnt_d = h_cnt_q + HCW'(1);
    v_cnt_d = v_cnt_q;
    if (h_ext == HT - 1) begin
      h_cnt_d = '0;
      v_cnt_d = (v_ext == VT - 1) ? '0 : v_cnt_q + VCW'(1);
    end
  end

  always_comb begin
    blank_d     = !active;
    hsync_d     = !((h_ext >= H_ACTIVE + H_FP) && (h_ext < H_ACTIVE + H_FP + H_SYNC));
    vsync_d     = !((v_ext >= V_ACTIVE + V_FP) && (v_ext < V_ACTIVE + V_FP + V_SYNC));
    underflow_d = underflow_q || (active && fifo_empty);
    d_d         = '0;
    if (active) d_d = fifo_empty ? UNDERFLOW_COLOR : expand_rgb444(head);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      blank_q     <= 1'b1;
      d_q         <= '0;
      underflow_q <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      blank_q     <= blank_d;
      d_q         <= d_d;
      underflow_q <= underflow_d;
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign blank     = blank_q;
  assign D         = d_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_dvi_fifo_scanout.sv
// Randomized bench for dvi_fifo_scanout against a position/queue reference model (reduced raster).
module tb_dvi_fifo_scanout;

  localparam int DEPTH = 16;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

`ifdef SCANOUT_UNDERFLOW_MARK_EN
  localparam logic [11:0] UC = 12'hF0F;
`else
  localparam logic [11:0] UC = 12'h000;
`endif

  logic        clk;
  logic        rst;
  logic [2:0]  color;
  logic        wr_en;
  logic        fifo_full, hsync, vsync, blank, underflow;
  logic [11:0] D;

  dvi_fifo_scanout #(
    .FIFO_DEPTH (DEPTH),
    .H_ACTIVE   (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE   (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk                            (clk),
    .rst                            (rst),
    .frame_buffer_color_in          (color),
    .frame_buffer_fifo_write_enable (wr_en),
    .fifo_full                      (fifo_full),
    .hsync                          (hsync),
    .vsync                          (vsync),
    .blank                          (blank),
    .D                              (D),
    .underflow                      (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  // Reference model: linear raster position since reset plus a queue of stored pixels.
  int          pos = 0;
  logic [2:0]  q[$];
  logic        uf_m = 1'b0;

  task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %03h expected %03h (pos %0d)", tag, got, exp, pos);
    end
  endtask

  function automatic logic [11:0] px(input logic [2:0] c);
    logic [11:0] r;
    r[11:8] = c[2] ? 4'hF : 4'h0;
    r[7:4]  = c[1] ? 4'hF : 4'h0;
    r[3:0]  = c[0] ? 4'hF : 4'h0;
    return r;
  endfunction

  task automatic step(input logic r, input logic we, input logic [2:0] c);
    int h, v, pre;
    bit act;
    logic e_hs, e_vs, e_bl;
    logic [11:0] e_d;
    rst = r; wr_en = we; color = c;
    if (r) begin
      e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b1; e_d = '0;
      uf_m = 1'b0; q.delete(); pos = 0;
    end else begin
      h    = pos % HT;
      v    = pos / HT;
      act  = (h < HA) && (v < VA);
      e_bl = !act;
      e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
      e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
      pre  = q.size();
      e_d  = 12'h000;
      if (act) e_d = (pre > 0) ? px(q[0]) : UC;
      if (act && pre == 0) uf_m = 1'b1;
      if (act && pre > 0) void'(q.pop_front());
      if (we && pre < DEPTH) q.push_back(c);
      pos = (pos + 1) % FT;
    end
    @(posedge clk);
    #1;
    check_eq("hsync", 12'(hsync), 12'(e_hs));
    check_eq("vsync", 12'(vsync), 12'(e_vs));
    check_eq("blank", 12'(blank), 12'(e_bl));
    check_eq("D", D, e_d);
    check_eq("underflow", 12'(underflow), 12'(uf_m));
    check_eq("fifo_full", 12'(fifo_full), 12'(q.size() == DEPTH));
  endtask

  // pct = percentage chance of a push attempt per cycle
  task automatic run(input int n, input int pct);
    for (int i = 0; i < n; i++)
      step(1'b0, ($urandom_range(99) < pct), 3'($urandom));
  endtask

  task automatic run_to(input int target, input int pct);
    int guard = 0;
    while (pos != target && guard < 2 * FT) begin
      step(1'b0, ($urandom_range(99) < pct), 3'($urandom));
      guard++;
    end
    check_eq("run_to_bound", 12'(pos == target), 12'd1);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; color = '0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 3'($urandom));

    // Active region with nothing pushed: underflow colour and sticky flag.
    run_to(VA * HT, 0);

    // Preload during vertical blanking: 17 pushes into 16 entries.
    step(1'b0, 1'b1, 3'b100);
    step(1'b0, 1'b1, 3'b010);
    step(1'b0, 1'b1, 3'b111);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 3'($urandom));
    run_to(0, 0);
    run(HT, 0);

    run(3 * FT, 50);

    // Mid-frame reset with the FIFO well stocked.
    run_to(3 * HT + 5, 95);
    step(1'b1, 1'b1, 3'($urandom));
    run(2 * FT, 60);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
